// File: rtl/bcd_countdown_timer_pkg.sv
// Shared state encodings and BCD constants for the mm:ss countdown timer.
package bcd_countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_e;

  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_FIVE = 4'd5;
  localparam logic [3:0] ADD_TENS = 4'd3;

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Keypad/control inputs and display/status outputs of the countdown timer.
interface bcd_countdown_timer_if #(
  parameter int MIN_DIGITS = 2
);
  logic                    digit_valid;
  logic [3:0]              digit_in;
  logic                    start;
  logic                    cancel;
  logic                    add30;
  logic [3:0]              sec_units;
  logic [3:0]              sec_tens;
  logic [4*MIN_DIGITS-1:0] minutes;
  logic                    running;
  logic                    zero;
  logic                    done;

  modport master (
    output digit_valid, digit_in, start, cancel, add30,
    input  sec_units, sec_tens, minutes, running, zero, done
  );

  modport slave (
    input  digit_valid, digit_in, start, cancel, add30,
    output sec_units, sec_tens, minutes, running, zero, done
  );
endinterface

// File: rtl/bcd_countdown_timer_digit_down.sv
// One BCD down-counting digit: load has priority over decrement, borrow out on 0 -> MODULUS-1.
module bcd_countdown_timer_digit_down #(
  parameter int MODULUS = 10
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       en_i,
  output logic [3:0] q_o,
  output logic       borrow_o,
  output logic       zero_o
);

  logic [3:0] q_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= 4'd0;
    end else if (load_i) begin
      q_q <= load_val_i;
    end else if (en_i) begin
      q_q <= (q_q == 4'd0) ? 4'(MODULUS - 1) : q_q - 4'd1;
    end
  end

  assign q_o      = q_q;
  assign zero_o   = (q_q == 4'd0);
  assign borrow_o = en_i & zero_o;

endmodule

// File: rtl/bcd_countdown_timer.sv
// mm:ss BCD countdown timer with keypad shift entry, seconds prescaler, pause and +30 s.
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int MIN_DIGITS = 2,
  parameter int TICK_DIV   = 50_000_000
) (
  input  logic clk_i,
  input  logic clear_i,
  bcd_countdown_timer_if.slave tmr
);

  // state     | meaning
  // ST_IDLE   | keypad entry, +30 s, start or quick-start
  // ST_RUN    | prescaler counting, one-second decrements
  // ST_PAUSED | time and prescaler frozen, resume or clear

  localparam int NDIG = MIN_DIGITS + 2;
  localparam int DW   = 4 * NDIG;
  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DISP_ONE = DW'(1);
  localparam logic [DW-1:0] THIRTY   = DW'(8'h30);
  localparam logic [DW-1:0] DISP_MAX = {{MIN_DIGITS{BCD_NINE}}, BCD_FIVE, BCD_NINE};

  state_e         state_q;
  logic [PW-1:0]  presc_q;
  logic           done_q;

  logic [DW-1:0]   disp, load_val, add30_val;
  logic [NDIG-1:0] dig_zero, dig_en, dig_borrow;
  logic [4:0]      tens_sum;
  logic            carry, load, count_en, tick, last_sec, zero;
  logic            unused_ms_borrow;

  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    bcd_countdown_timer_digit_down #(
      .MODULUS ((g == 1) ? 6 : 10)
    ) u_digit (
      .clk_i      (clk_i),
      .rst_i      (clear_i),
      .load_i     (load),
      .load_val_i (load_val[4*g +: 4]),
      .en_i       (dig_en[g]),
      .q_o        (disp[4*g +: 4]),
      .borrow_o   (dig_borrow[g]),
      .zero_o     (dig_zero[g])
    );
  end

  assign dig_en           = {dig_borrow[NDIG-2:0], tick};
  assign unused_ms_borrow = dig_borrow[NDIG-1];
  assign zero             = &dig_zero;
  assign last_sec         = (disp == DISP_ONE);

  // A start pulse in RUN still lets the prescaler run; only a winning add30 defers it.
  assign count_en = (state_q == ST_RUN) && !tmr.cancel && (tmr.start || !tmr.add30);
  assign tick     = count_en && (presc_q == PRE_MAX);

  always_comb begin
    add30_val      = disp;
    tens_sum       = {1'b0, disp[7:4]} + {1'b0, ADD_TENS};
    carry          = (tens_sum > {1'b0, BCD_FIVE});
    add30_val[7:4] = carry ? 4'(tens_sum - 5'd6) : tens_sum[3:0];
    for (int k = 0; k < MIN_DIGITS; k++) begin
      if (carry) begin
        if (disp[8+4*k +: 4] == BCD_NINE) begin
          add30_val[8+4*k +: 4] = 4'd0;
        end else begin
          add30_val[8+4*k +: 4] = disp[8+4*k +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    if (carry) add30_val = DISP_MAX;
  end

  always_comb begin
    load     = 1'b0;
    load_val = disp;
    case (state_q)
      ST_IDLE: begin
        if (tmr.cancel) begin
          load     = 1'b1;
          load_val = '0;
        end else if (!tmr.start) begin
          if (tmr.add30) begin
            load     = 1'b1;
            load_val = zero ? THIRTY : add30_val;
          end else if (tmr.digit_valid && tmr.digit_in <= BCD_NINE) begin
            load     = 1'b1;
            load_val = {disp[DW-5:0], tmr.digit_in};
          end
        end
      end
      ST_RUN: begin
        if (!tmr.cancel && !tmr.start && tmr.add30) begin
          load     = 1'b1;
          load_val = add30_val;
        end
      end
      ST_PAUSED: begin
        if (tmr.cancel) begin
          load     = 1'b1;
          load_val = '0;
        end else if (!tmr.start && tmr.add30) begin
          load     = 1'b1;
          load_val = add30_val;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!tmr.cancel) begin
            if (tmr.start) begin
              if (!zero && disp[7:4] <= BCD_FIVE) begin
                state_q <= ST_RUN;
                presc_q <= '0;
              end
            end else if (tmr.add30 && zero) begin
              state_q <= ST_RUN;
              presc_q <= '0;
            end
          end
        end
        ST_RUN: begin
          if (tmr.cancel) begin
            state_q <= ST_PAUSED;
          end else if (count_en) begin
            if (tick) begin
              presc_q <= '0;
              if (last_sec) begin
                state_q <= ST_IDLE;
                done_q  <= 1'b1;
              end
            end else begin
              presc_q <= presc_q + 1'b1;
            end
          end
        end
        ST_PAUSED: begin
          if (tmr.cancel) begin
            state_q <= ST_IDLE;
          end else if (tmr.start) begin
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tmr.sec_units = disp[3:0];
  assign tmr.sec_tens  = disp[7:4];
  assign tmr.minutes   = disp[DW-1:8];
  assign tmr.zero      = zero;
  assign tmr.running   = (state_q == ST_RUN);
  assign tmr.done      = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer with MIN_DIGITS=2, TICK_DIV=4.
module tb_bcd_countdown_timer;

  logic clk = 1'b0;
  logic clear;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   done_cnt = 0;

  bcd_countdown_timer_if #(.MIN_DIGITS(2)) bus ();

  bcd_countdown_timer #(
    .MIN_DIGITS (2),
    .TICK_DIV   (4)
  ) dut (
    .clk_i   (clk),
    .clear_i (clear),
    .tmr     (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] disp;
  assign disp = {bus.minutes, bus.sec_tens, bus.sec_units};

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    bus.digit_valid = 1'b1;
    bus.digit_in    = d;
    clk1();
    bus.digit_valid = 1'b0;
    bus.digit_in    = 4'd0;
  endtask

  task automatic pulse(input logic s, input logic c, input logic a);
    bus.start  = s;
    bus.cancel = c;
    bus.add30  = a;
    clk1();
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.add30  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1;
    bus.digit_valid = 1'b0;
    bus.digit_in    = 4'd0;
    bus.start       = 1'b0;
    bus.cancel      = 1'b0;
    bus.add30       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_disp", 32'(disp), 32'h0000);
    check("rst_zero", 32'(bus.zero), 32'd1);
    check("rst_running", 32'(bus.running), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    clear = 1'b0;
    clk1();

    // 1: shift entry
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    check("entry_minutes", 32'(bus.minutes), 32'h12);
    check("entry_tens", 32'(bus.sec_tens), 32'd3);
    check("entry_units", 32'(bus.sec_units), 32'd4);
    check("entry_zero", 32'(bus.zero), 32'd0);

    // 2: 0:05 full countdown
    pulse(1'b0, 1'b1, 1'b0);
    check("idle_cancel", 32'(disp), 32'h0000);
    key(4'd0); key(4'd5);
    pulse(1'b1, 1'b0, 1'b0);
    check("run_start", 32'(bus.running), 32'd1);
    repeat (3) clk1();
    check("pre_tick", 32'(disp), 32'h0005);
    clk1();
    check("first_tick", 32'(disp), 32'h0004);
    repeat (15) clk1();
    check("at_0001", 32'(disp), 32'h0001);
    check("at_0001_done", 32'(bus.done), 32'd0);
    clk1();
    check("end_disp", 32'(disp), 32'h0000);
    check("end_done", 32'(bus.done), 32'd1);
    check("end_running", 32'(bus.running), 32'd0);
    clk1();
    check("done_one_cycle", 32'(bus.done), 32'd0);

    // 3: borrow across tens and minutes
    key(4'd1); key(4'd0); key(4'd0);
    pulse(1'b1, 1'b0, 1'b0);
    repeat (3) clk1();
    check("b_pre", 32'(disp), 32'h0100);
    clk1();
    check("b_0059", 32'(disp), 32'h0059);
    repeat (4) clk1();
    check("b_0058", 32'(disp), 32'h0058);
    pulse(1'b0, 1'b1, 1'b0);
    check("b_paused", 32'(bus.running), 32'd0);
    pulse(1'b0, 1'b1, 1'b0);
    check("b_cleared", 32'(disp), 32'h0000);

    // 4: pause with prescaler held at 2
    key(4'd1); key(4'd0);
    pulse(1'b1, 1'b0, 1'b0);
    repeat (2) clk1();
    pulse(1'b0, 1'b1, 1'b0);
    check("p_running", 32'(bus.running), 32'd0);
    repeat (8) clk1();
    check("p_frozen", 32'(disp), 32'h0010);
    pulse(1'b1, 1'b0, 1'b0);
    check("p_resume", 32'(bus.running), 32'd1);
    clk1();
    check("p_resume_hold", 32'(disp), 32'h0010);
    clk1();
    check("p_resume_tick", 32'(disp), 32'h0009);
    pulse(1'b1, 1'b1, 1'b0);
    check("cancel_over_start", 32'(bus.running), 32'd0);
    check("cancel_over_start_disp", 32'(disp), 32'h0009);
    pulse(1'b0, 1'b1, 1'b0);

    // 5: add30
    pulse(1'b0, 1'b0, 1'b1);
    check("quick_disp", 32'(disp), 32'h0030);
    check("quick_running", 32'(bus.running), 32'd1);
    repeat (4) clk1();
    check("quick_tick", 32'(disp), 32'h0029);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    key(4'd4); key(4'd5);
    pulse(1'b1, 1'b0, 1'b0);
    repeat (2) clk1();
    pulse(1'b0, 1'b0, 1'b1);
    check("add30_run", 32'(disp), 32'h0115);
    clk1();
    check("add30_defer", 32'(disp), 32'h0115);
    clk1();
    check("add30_tick", 32'(disp), 32'h0114);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    key(4'd0); key(4'd1); key(4'd4); key(4'd5);
    pulse(1'b0, 1'b0, 1'b1);
    check("add30_idle", 32'(disp), 32'h0215);
    check("add30_idle_state", 32'(bus.running), 32'd0);
    pulse(1'b0, 1'b1, 1'b0);
    key(4'd9); key(4'd9); key(4'd4); key(4'd5);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    check("add30_sat", 32'(disp), 32'h9959);
    check("add30_sat_run", 32'(bus.running), 32'd1);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);

    // 6: invalid key, invalid start, clear mid-run
    key(4'd7); key(4'hA);
    check("bad_key", 32'(disp), 32'h0007);
    pulse(1'b0, 1'b1, 1'b0);
    key(4'd7); key(4'd5);
    pulse(1'b1, 1'b0, 1'b0);
    check("bad_start", 32'(bus.running), 32'd0);
    check("bad_start_disp", 32'(disp), 32'h0075);
    pulse(1'b0, 1'b1, 1'b0);
    key(4'd2);
    pulse(1'b1, 1'b0, 1'b0);
    repeat (2) clk1();
    clear = 1'b1;
    #1;
    check("clr_disp", 32'(disp), 32'h0000);
    check("clr_running", 32'(bus.running), 32'd0);
    check("clr_zero", 32'(bus.zero), 32'd1);
    repeat (2) clk1();
    clear = 1'b0;
    repeat (12) clk1();
    check("clr_stay", 32'(disp), 32'h0000);
    check("done_total", 32'(done_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
